// File: rtl/if_fetch_pkg.sv
// Shared widths, reset level and fetch FSM encoding for the
// instruction fetch stage.
package if_fetch_pkg;

   localparam int ADDR_LEN = 32;
   localparam int INST_LEN = 32;
   localparam logic RESET_ENABLE = 1'b1;

   typedef enum logic [2:0] {
      IF_IDLE  = 3'd0,
      IF_REQ   = 3'd1,
      IF_WAIT  = 3'd2,
      IF_HOLD  = 3'd3,
      IF_DRAIN = 3'd4
   } if_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC and assembles each 32-bit
// instruction from four little-endian byte reads.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_LEN,
   parameter int INST_W = INST_LEN,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              jump_i,
   input  logic [ADDR_W-1:0] jump_target_i,
   input  logic              mem_busy_i,
   input  logic              mem_ack_i,
   input  logic [7:0]        mem_rdata_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [INST_W-1:0] inst_o,
   output logic              valid_o
);

   if_state_t         state;
   if_state_t         state_nx;
   logic [ADDR_W-1:0] fpc;
   logic [ADDR_W-1:0] fpc_nx;
   logic [1:0]        cnt;
   logic [1:0]        cnt_nx;
   logic [23:0]       lo_bytes;
   logic [23:0]       lo_bytes_nx;
   logic [ADDR_W-1:0] pc_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [INST_W-1:0] inst_nx;
   logic              valid_nx;
   logic              req_nx;
   logic              accept;

   always_comb begin
      state_nx    = state;
      fpc_nx      = fpc;
      cnt_nx      = cnt;
      lo_bytes_nx = lo_bytes;
      pc_nx       = pc_o;
      inst_nx     = inst_o;
      valid_nx    = valid_o;
      req_nx      = mem_req_o;
      addr_nx     = mem_addr_o;
      accept      = mem_req_o & ~mem_busy_i;

      if (jump_i) begin
         fpc_nx   = jump_target_i;
         cnt_nx   = '0;
         valid_nx = 1'b0;
         // A request already accepted must still be drained before reissuing.
         unique case (state)
            IF_WAIT, IF_DRAIN: state_nx = mem_ack_i ? IF_REQ : IF_DRAIN;
            IF_REQ:            state_nx = accept ? IF_DRAIN : IF_REQ;
            default:           state_nx = IF_REQ;
         endcase
         req_nx = (state_nx == IF_REQ);
         if (req_nx) begin
            addr_nx = jump_target_i;
         end
      end else begin
         unique case (state)
            IF_IDLE: begin
               state_nx = IF_REQ;
               req_nx   = 1'b1;
               addr_nx  = fpc;
               cnt_nx   = '0;
            end
            IF_REQ: begin
               if (accept) begin
                  req_nx   = 1'b0;
                  state_nx = IF_WAIT;
               end
            end
            IF_WAIT: begin
               if (mem_ack_i) begin
                  if (cnt == 2'd3) begin
                     inst_nx  = INST_W'({mem_rdata_i, lo_bytes});
                     pc_nx    = fpc;
                     valid_nx = 1'b1;
                     fpc_nx   = fpc + ADDR_W'(4);
                     state_nx = IF_HOLD;
                  end else begin
                     unique case (cnt)
                        2'd0:    lo_bytes_nx[7:0]   = mem_rdata_i;
                        2'd1:    lo_bytes_nx[15:8]  = mem_rdata_i;
                        default: lo_bytes_nx[23:16] = mem_rdata_i;
                     endcase
                     cnt_nx   = cnt + 2'd1;
                     state_nx = IF_REQ;
                     req_nx   = 1'b1;
                     addr_nx  = fpc + ADDR_W'(cnt_nx);
                  end
               end
            end
            IF_HOLD: begin
               if (!stall_i) begin
                  valid_nx = 1'b0;
                  cnt_nx   = '0;
                  state_nx = IF_REQ;
                  req_nx   = 1'b1;
                  addr_nx  = fpc;
               end
            end
            IF_DRAIN: begin
               if (mem_ack_i) begin
                  state_nx = IF_REQ;
                  req_nx   = 1'b1;
                  addr_nx  = fpc;
               end
            end
            default: begin
               state_nx = IF_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RESET_ENABLE) begin
         state      <= IF_IDLE;
         fpc        <= RESET_PC;
         cnt        <= '0;
         lo_bytes   <= '0;
         pc_o       <= RESET_PC;
         inst_o     <= '0;
         valid_o    <= 1'b0;
         mem_req_o  <= 1'b0;
         mem_addr_o <= '0;
      end else begin
         state      <= state_nx;
         fpc        <= fpc_nx;
         cnt        <= cnt_nx;
         lo_bytes   <= lo_bytes_nx;
         pc_o       <= pc_nx;
         inst_o     <= inst_nx;
         valid_o    <= valid_nx;
         mem_req_o  <= req_nx;
         mem_addr_o <= addr_nx;
      end
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch stage for the 5-stage RV32I pipeline.
- Owns the PC, reads each 32-bit instruction from the byte-wide memory controller as four little-endian byte reads, and presents {pc, inst} to the IF/ID register, which feeds the decoder.
- Accepts pipeline stalls and jump/branch redirects from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, address and PC width (`AddrLen)
INST_W, 32, instruction width (`InstLen)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high (`ResetEnable), sampled on rising clk
stall_i  in  1  downstream stall; hold the current output instruction
jump_i  in  1  redirect request from EX (taken branch, JAL, JALR)
jump_target_i  in  ADDR_W  redirect PC
mem_busy_i  in  1  memory controller cannot accept a request this cycle
mem_ack_i  in  1  requested byte is valid on mem_rdata_i this cycle
mem_rdata_i  in  8  returned byte
mem_req_o  out  1  byte read request (level, held until accepted)
mem_addr_o  out  ADDR_W  byte address of the request
pc_o  out  ADDR_W  PC of the presented instruction
inst_o  out  INST_W  presented instruction
valid_o  out  1  pc_o and inst_o hold a complete instruction

Behaviour:
- All outputs are registered.
- Reset, synchronous and with priority over everything else:
  - pc_o = RESET_PC, inst_o = 0, valid_o = 0, mem_req_o = 0, mem_addr_o = 0.
  - Internal fetch PC = RESET_PC, byte count = 0, state = IDLE.
  - Reset mid-fetch abandons any outstanding byte. Any later ack is ignored because state is IDLE or REQ with no request outstanding.
- Memory protocol:
  - A request is accepted on an edge where mem_req_o = 1 and mem_busy_i = 0.
  - At most one request is outstanding.
  - mem_ack_i arrives on a later edge, at least 1 cycle after acceptance.
  - Acks arriving with no request outstanding are ignored.
- States: IDLE, REQ, WAIT, HOLD, DRAIN.
  - IDLE: on the cycle after reset, go to REQ with mem_addr_o = fpc, cnt = 0.
  - REQ: mem_req_o = 1, mem_addr_o = fpc + cnt. On acceptance: mem_req_o <= 0, go to WAIT.
  - WAIT: on ack, write byte cnt into buf[8*cnt+7 : 8*cnt].
    - If cnt < 3: cnt <= cnt + 1, go to REQ with the next address.
    - If cnt = 3: inst_o <= {byte3, buf[23:0]}, pc_o <= fpc, valid_o <= 1, fpc <= fpc + 4, go to HOLD.
  - HOLD: while stall_i = 1, hold all outputs. On an edge with stall_i = 0, the instruction is consumed: valid_o <= 0, cnt <= 0, go to REQ.
- Throughput: 2 cycles per byte minimum, so 8 cycles per instruction with no busy; plus 1 HOLD cycle.
- Redirect (jump_i = 1 at an edge, any state except reset):
  - fpc <= jump_target_i, cnt <= 0, valid_o <= 0.
  - From IDLE, REQ or HOLD: go to REQ. In REQ, the pending unaccepted request is withdrawn and replaced by the target address.
  - From WAIT with no ack on the same edge: go to DRAIN.
  - From WAIT with ack on the same edge: the byte is discarded and the FSM goes to REQ.
  - DRAIN: mem_req_o = 0. On ack, discard the byte and go to REQ. A new jump_i in DRAIN updates fpc and stays in DRAIN.
- jump_i takes priority over stall_i and over completion: a completing 4th byte on the same edge as jump_i is discarded.
- Redirect while valid_o = 1 and stall_i = 1: the instruction is still flushed. EX guarantees it is wrong-path.
- The address is not aligned. A misaligned target fetches bytes at target..target+3. The PC increment wraps mod 2^ADDR_W.

Decomposition:
- defines.v gets `AddrLen, `InstLen, `ResetEnable and the fetch state encodings (`IF_IDLE .. `IF_DRAIN, 3 bits).
- No sub-module: the single FSM plus byte buffer fits comfortably in one module.

Test Plan:
- Reset, then memory returning bytes 13,05,00,00 at 0..3 with 1-cycle ack, no busy: first request addresses 0,1,2,3; valid_o rises 8 cycles after the first request; inst_o = 32'h0000_0513, pc_o = 0.
- stall_i held for 5 cycles in HOLD: pc_o, inst_o and valid_o stay constant and mem_req_o = 0. Release: the next request goes to address 4, and pc_o = 4 on the next completion.
- mem_busy_i = 1 for 3 cycles during REQ for byte 2: mem_req_o and mem_addr_o = 2 are held; the byte is accepted on the first non-busy edge.
- jump_i with target 32'h100 while in WAIT for byte 1 with ack delayed 3 cycles: the late byte is discarded (DRAIN), the next request goes to 0x100, and pc_o = 0x100 with bytes from 0x100.
- jump_i on the same edge as the 4th-byte ack: valid_o stays 0, and the next request goes to the target.
- rst asserted mid-WAIT, then a stray ack arrives: outputs return to reset values, the stray ack has no effect, and fetch restarts at RESET_PC.
